// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for the 16-bit multicycle processor. Each instruction is
// stepped through FETCH / DECODE / EXEC / MEM / WB (plus BRANCH, JUMP and a
// MULTI state that walks an 8-bit register mask for LM/SM). The datapath
// strobes are combinational from the current state, the opcode latched in
// DECODE, the IR fields and the memory/ALU status inputs.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   instr[15:0]          : IR contents (op [15:12], RA [11:9], RB [8:6],
//                          RC [5:3], mask [7:0])
//   mem_ack              : memory completes the current access this cycle
//   alu_zero, alu_neg    : ALU result status
//   mem_req/mem_we       : memory request / write qualifier
//   addr_sel             : address source, 0 = PC, 1 = T3
//   ir_load, pc_load     : IR / PC load strobes
//   pc_sel[1:0]          : 00 PC+1, 01 PC+sext(imm), 10 RB value
//   t_load               : T1<-R[RA], T2<-R[RB]
//   alu_op[1:0]          : 00 add, 01 nand, 10 sub, 11 pass-B
//   alu_src_b            : 0 = T2, 1 = sext(imm)
//   t3_load, t3_inc      : T3<-ALU, T3<-T3+1
//   rf_we, rf_waddr[2:0] : register-file write port
//   rf_wsel[1:0]         : write data, 00 T3, 01 mem, 10 PC, 11 imm
//   flags_load           : load carry/zero flags
//   illegal              : sticky illegal-opcode indicator (HALT)
//   state[3:0]           : current state, debug only
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        mem_ack,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_load,
    output logic        pc_load,
    output logic [1:0]  pc_sel,
    output logic        t_load,
    output logic [1:0]  alu_op,
    output logic        alu_src_b,
    output logic        t3_load,
    output logic        t3_inc,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [1:0]  rf_wsel,
    output logic        flags_load,
    output logic        illegal,
    output logic [3:0]  state
);

    // The block never times out on memory; any other value is a build error.
    if (MEM_TIMEOUT != 0) begin : g_mem_timeout_check
        $error("MEM_TIMEOUT is reserved and must be 0");
    end

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_MULTI  = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    // Opcodes
    localparam logic [3:0] OP_ADI  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_LLI  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_LM   = 4'h6;
    localparam logic [3:0] OP_SM   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BLT  = 4'h9;
    localparam logic [3:0] OP_BLE  = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hC;
    localparam logic [3:0] OP_JLR  = 4'hD;
    localparam logic [3:0] OP_JRI  = 4'hF;

    // Datapath select codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;

    localparam logic [1:0] WSEL_T3  = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;
    localparam logic [1:0] WSEL_IMM = 2'b11;

    state_t      cur;
    state_t      nxt;
    logic [3:0]  opc_q;    // opcode class latched in DECODE
    logic [7:0]  mask_q;   // LM/SM register mask latched in DECODE
    logic [2:0]  idx_q;    // LM/SM mask bit position
    logic        idx_adv;  // step idx_q this cycle
    logic        taken;    // branch condition

    logic [3:0]  op_now;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rc;
    logic        mask_bit;

    assign op_now   = instr[15:12];
    assign ra       = instr[11:9];
    assign rb       = instr[8:6];
    assign rc       = instr[5:3];
    assign mask_bit = mask_q[idx_q];
    assign state    = cur;

    always_comb begin
        taken = 1'b0;
        case (opc_q)
            OP_BEQ:  taken = alu_zero;
            OP_BLT:  taken = alu_neg;
            OP_BLE:  taken = alu_zero | alu_neg;
            default: taken = 1'b0;
        endcase
    end

    // Next state and datapath strobes
    always_comb begin
        nxt        = cur;
        idx_adv    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_load    = 1'b0;
        pc_sel     = PC_INC;
        t_load     = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_b  = 1'b0;
        t3_load    = 1'b0;
        t3_inc     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 3'd0;
        rf_wsel    = WSEL_T3;
        flags_load = 1'b0;
        illegal    = 1'b0;

        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_load = 1'b1;
                    pc_sel  = PC_INC;
                    nxt     = S_DECODE;
                end
            end

            S_DECODE: begin
                t_load = 1'b1;
                case (op_now)
                    OP_ADI, OP_ADD, OP_NAND, OP_LW, OP_SW,
                    OP_BEQ, OP_BLT, OP_BLE:
                        nxt = S_EXEC;
                    OP_LLI:
                        nxt = S_WB;
                    OP_LM, OP_SM: begin
                        // Seed T3 with the base address (RB) so MULTI can
                        // start issuing accesses immediately.
                        alu_op    = ALU_PASS;
                        alu_src_b = 1'b0;
                        t3_load   = 1'b1;
                        nxt       = S_MULTI;
                    end
                    OP_JAL, OP_JLR, OP_JRI:
                        nxt = S_JUMP;
                    default:
                        nxt = S_HALT;
                endcase
            end

            S_EXEC: begin
                case (opc_q)
                    OP_ADD, OP_NAND: begin
                        alu_op     = (opc_q == OP_NAND) ? ALU_NAND : ALU_ADD;
                        alu_src_b  = 1'b0;
                        t3_load    = 1'b1;
                        flags_load = 1'b1;
                        nxt        = S_WB;
                    end
                    OP_ADI: begin
                        alu_op     = ALU_ADD;
                        alu_src_b  = 1'b1;
                        t3_load    = 1'b1;
                        flags_load = 1'b1;
                        nxt        = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        // Effective address; flags are not touched.
                        alu_op    = ALU_ADD;
                        alu_src_b = 1'b1;
                        t3_load   = 1'b1;
                        nxt       = (opc_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                    end
                    OP_BEQ, OP_BLT, OP_BLE: begin
                        // Compare only; status is consumed next cycle.
                        alu_op    = ALU_SUB;
                        alu_src_b = 1'b0;
                        nxt       = S_BRANCH;
                    end
                    default:
                        nxt = S_FETCH;
                endcase
            end

            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack) begin
                    rf_we    = 1'b1;
                    rf_wsel  = WSEL_MEM;
                    rf_waddr = ra;
                    nxt      = S_FETCH;
                end
            end

            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                if (mem_ack)
                    nxt = S_FETCH;
            end

            S_WB: begin
                nxt = S_FETCH;
                case (opc_q)
                    OP_ADD, OP_NAND: begin
                        rf_we    = 1'b1;
                        rf_waddr = rc;
                        rf_wsel  = WSEL_T3;
                    end
                    OP_ADI: begin
                        rf_we    = 1'b1;
                        rf_waddr = rb;
                        rf_wsel  = WSEL_T3;
                    end
                    OP_LLI: begin
                        rf_we    = 1'b1;
                        rf_waddr = ra;
                        rf_wsel  = WSEL_IMM;
                    end
                    default: rf_we = 1'b0;
                endcase
            end

            S_BRANCH: begin
                if (taken) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_REL;
                end
                nxt = S_FETCH;
            end

            S_JUMP: begin
                // Link uses the PC already incremented in FETCH.
                rf_we    = 1'b1;
                rf_wsel  = WSEL_PC;
                rf_waddr = ra;
                pc_load  = 1'b1;
                pc_sel   = (opc_q == OP_JLR) ? PC_REG : PC_REL;
                nxt      = S_FETCH;
            end

            S_MULTI: begin
                // One mask bit per cycle (plus wait cycles); always 8 slots.
                if (!mask_bit) begin
                    idx_adv = 1'b1;
                    if (idx_q == 3'd7)
                        nxt = S_FETCH;
                end else begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opc_q == OP_SM);
                    if (mem_ack) begin
                        t3_inc  = 1'b1;
                        idx_adv = 1'b1;
                        if (opc_q == OP_LM) begin
                            rf_we    = 1'b1;
                            rf_wsel  = WSEL_MEM;
                            rf_waddr = idx_q;
                        end
                        if (idx_q == 3'd7)
                            nxt = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                illegal = 1'b1;
            end

            default: nxt = S_FETCH;
        endcase

        // Reset silences every strobe so a pending access is dropped cleanly.
        if (reset) begin
            idx_adv    = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            addr_sel   = 1'b0;
            ir_load    = 1'b0;
            pc_load    = 1'b0;
            pc_sel     = PC_INC;
            t_load     = 1'b0;
            alu_op     = ALU_ADD;
            alu_src_b  = 1'b0;
            t3_load    = 1'b0;
            t3_inc     = 1'b0;
            rf_we      = 1'b0;
            rf_waddr   = 3'd0;
            rf_wsel    = WSEL_T3;
            flags_load = 1'b0;
            illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= S_FETCH;
            opc_q  <= 4'd0;
            mask_q <= 8'd0;
            idx_q  <= 3'd0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                opc_q  <= op_now;
                mask_q <= instr[7:0];
                idx_q  <= 3'd0;
            end else if (idx_adv) begin
                idx_q  <= idx_q + 3'd1;   // 7 wraps to 0 as MULTI exits
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        mem_ack;
    logic        alu_zero;
    logic        alu_neg;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_load;
    logic [1:0]  pc_sel;
    logic        t_load;
    logic [1:0]  alu_op;
    logic        alu_src_b, t3_load, t3_inc, rf_we;
    logic [2:0]  rf_waddr;
    logic [1:0]  rf_wsel;
    logic        flags_load, illegal;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_TIMEOUT(0)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ack(mem_ack),
        .alu_zero(alu_zero), .alu_neg(alu_neg),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
        .t_load(t_load), .alu_op(alu_op), .alu_src_b(alu_src_b),
        .t3_load(t3_load), .t3_inc(t3_inc), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .flags_load(flags_load),
        .illegal(illegal), .state(state)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Per-instruction observation log
    logic [3:0] st_q[$];
    bit         req_q[$];
    bit         asel_q[$];
    bit         rfwe_q[$];
    logic [4:0] wr_q[$];     // {waddr, wsel}
    logic [1:0] pcs_q[$];    // pc_sel of each pc_load
    bit         accwe_q[$];  // mem_we of each completed access
    int         t3i, fl, waits, cyc;
    bit         timeout;

    // Reference expectations
    int         e_base, e_t3i, e_fl;
    logic [4:0] e_wr[$];
    logic [1:0] e_pcs[$];
    bit         e_acc[$];

    function automatic int pick(input int dwait, input bit is_fetch);
        if (dwait < 0) return int'($urandom_range(0, 2));
        return is_fetch ? 0 : dwait;
    endfunction

    function automatic logic [15:0] outs_vec();
        return {mem_req, mem_we, addr_sel, ir_load, pc_load, pc_sel, t_load,
                alu_op, alu_src_b, t3_load, t3_inc, rf_we, rf_waddr, rf_wsel,
                flags_load, illegal};
    endfunction

    // Instruction-level model: cycle cost, writes, PC loads, accesses.
    task automatic build_model(input logic [15:0] ins, input bit z, input bit n);
        logic [3:0] op;
        logic [2:0] ra, rb, rc;
        bit         tk;
        op = ins[15:12]; ra = ins[11:9]; rb = ins[8:6]; rc = ins[5:3];
        e_wr.delete(); e_pcs.delete(); e_acc.delete();
        e_pcs.push_back(2'b00);          // fetch PC+1
        e_acc.push_back(1'b0);           // fetch read
        e_t3i = 0; e_fl = 0; e_base = 0;
        case (op)
            4'h1, 4'h2: begin e_base = 4; e_wr.push_back({rc, 2'd0}); e_fl = 1; end
            4'h0:       begin e_base = 4; e_wr.push_back({rb, 2'd0}); e_fl = 1; end
            4'h3:       begin e_base = 3; e_wr.push_back({ra, 2'd3}); end
            4'h4:       begin e_base = 4; e_wr.push_back({ra, 2'd1}); e_acc.push_back(1'b0); end
            4'h5:       begin e_base = 4; e_acc.push_back(1'b1); end
            4'h8, 4'h9, 4'hA: begin
                e_base = 4;
                tk = (op == 4'h8) ? z : (op == 4'h9) ? n : (z | n);
                if (tk) e_pcs.push_back(2'b01);
            end
            4'hC, 4'hF: begin e_base = 3; e_wr.push_back({ra, 2'd2}); e_pcs.push_back(2'b01); end
            4'hD:       begin e_base = 3; e_wr.push_back({ra, 2'd2}); e_pcs.push_back(2'b10); end
            4'h6, 4'h7: begin
                e_base = 10;
                for (int i = 0; i < 8; i++) begin
                    if (ins[i]) begin
                        e_acc.push_back(op == 4'h7);
                        e_t3i++;
                        if (op == 4'h6) e_wr.push_back({3'(i), 2'd1});
                    end
                end
            end
            default: e_base = 0;
        endcase
    endtask

    // Runs one instruction from FETCH back to FETCH with a responding memory.
    // dwait < 0: random 0..2 wait cycles per access; else fetch 0, data dwait.
    task automatic run_instr(input logic [15:0] ins, input int dwait,
                             input bit z, input bit n);
        int wc;
        bit fetched;
        st_q.delete(); req_q.delete(); asel_q.delete(); rfwe_q.delete();
        wr_q.delete(); pcs_q.delete(); accwe_q.delete();
        t3i = 0; fl = 0; waits = 0; cyc = 0; timeout = 0; fetched = 0;
        instr = ins; alu_zero = z; alu_neg = n;
        wc = pick(dwait, 1'b1);
        forever begin
            mem_ack = mem_req && (wc == 0);
            #1;
            st_q.push_back(state);
            req_q.push_back(mem_req);
            asel_q.push_back(addr_sel);
            rfwe_q.push_back(rf_we);
            if (rf_we) wr_q.push_back({rf_waddr, rf_wsel});
            if (pc_load) pcs_q.push_back(pc_sel);
            if (mem_req && mem_ack) accwe_q.push_back(mem_we);
            t3i += int'(t3_inc);
            fl  += int'(flags_load);
            if (ir_load) fetched = 1;
            if (mem_req && !mem_ack) begin wc--; waits++; end
            else if (mem_req && mem_ack) wc = pick(dwait, 1'b0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            cyc++;
            if (fetched && state == 4'd0) break;
            if (cyc >= 200) begin timeout = 1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b1; alu_zero = 1'b1; alu_neg = 1'b1;
        instr = 16'h1298;
        @(posedge clk); @(posedge clk); #2;
        n_chk++;
        if (state !== 4'd0) $display("FAIL reset_state got %0d want 0", state);
        else n_pass++;
        n_chk++;
        if (outs_vec() !== 16'h0) $display("FAIL reset_outputs got %h want 0000", outs_vec());
        else n_pass++;
        mem_ack = 1'b0;
        reset = 1'b0; #1;
        n_chk++;
        if (mem_req !== 1'b1 || addr_sel !== 1'b0)
            $display("FAIL first_fetch got req=%b asel=%b want req=1 asel=0", mem_req, addr_sel);
        else n_pass++;
    endtask

    task automatic test_add_trace();
        run_instr(16'h1298, 0, 1'b0, 1'b0);
        n_chk++;
        if (timeout || cyc != 4 || st_q.size() != 4 || st_q[0] !== 4'd0 || st_q[1] !== 4'd1 ||
            st_q[2] !== 4'd2 || st_q[3] !== 4'd5 || state !== 4'd0)
            $display("FAIL add_states got cyc=%0d seq=%p end=%0d want 0,1,2,5 then 0", cyc, st_q, state);
        else n_pass++;
        n_chk++;
        if (rfwe_q.size() != 4 || rfwe_q[3] !== 1'b1 || wr_q.size() != 1 || wr_q[0] !== {3'd3, 2'd0})
            $display("FAIL add_wb got writes=%p want {waddr3,wsel0} in WB", wr_q);
        else n_pass++;
    endtask

    task automatic test_lw_wait();
        run_instr(16'h4A85, 2, 1'b0, 1'b0);
        n_chk++;
        if (timeout || cyc != 6 || st_q.size() != 6 || st_q[3] !== 4'd3 || st_q[5] !== 4'd3)
            $display("FAIL lw_states got cyc=%0d seq=%p want 6 cycles ending 3,3,3", cyc, st_q);
        else n_pass++;
        n_chk++;
        if (req_q.size() != 6 || !(req_q[3] && req_q[4] && req_q[5] && asel_q[3] && asel_q[4] && asel_q[5]))
            $display("FAIL lw_req_hold got req=%p asel=%p want 1,1,1 in MEM_RD", req_q, asel_q);
        else n_pass++;
        n_chk++;
        if (rfwe_q.size() != 6 || rfwe_q[3] || rfwe_q[4] || !rfwe_q[5] ||
            wr_q.size() != 1 || wr_q[0] !== {3'd5, 2'd1})
            $display("FAIL lw_write got rfwe=%p writes=%p want 0,0,1 waddr5 wsel1", rfwe_q, wr_q);
        else n_pass++;
    endtask

    task automatic test_branch();
        run_instr(16'h8000, 0, 1'b1, 1'b0);
        n_chk++;
        if (timeout || pcs_q.size() != 2 || pcs_q[1] !== 2'b01)
            $display("FAIL beq_taken got pc_loads=%p want 00,01", pcs_q);
        else n_pass++;
        run_instr(16'h8000, 0, 1'b0, 1'b1);
        n_chk++;
        if (timeout || pcs_q.size() != 1)
            $display("FAIL beq_not_taken got pc_loads=%p want 00 only", pcs_q);
        else n_pass++;
        run_instr(16'hA000, 0, 1'b0, 1'b1);
        n_chk++;
        if (timeout || pcs_q.size() != 2 || pcs_q[1] !== 2'b01)
            $display("FAIL ble_taken got pc_loads=%p want 00,01", pcs_q);
        else n_pass++;
    endtask

    task automatic test_lm();
        int nm;
        run_instr(16'h6A05, 0, 1'b0, 1'b0);
        nm = 0;
        foreach (st_q[i]) if (st_q[i] == 4'd6) nm++;
        n_chk++;
        if (timeout || wr_q.size() != 2 || wr_q[0] !== {3'd0, 2'd1} || wr_q[1] !== {3'd2, 2'd1})
            $display("FAIL lm_writes got %p want waddr0,waddr2 wsel1", wr_q);
        else n_pass++;
        n_chk++;
        if (t3i != 2 || accwe_q.size() != 3)
            $display("FAIL lm_accesses got t3_inc=%0d accesses=%0d want 2 and 3", t3i, accwe_q.size());
        else n_pass++;
        n_chk++;
        if (nm != 8 || cyc != 10 || state !== 4'd0)
            $display("FAIL lm_multi_cycles got multi=%0d cyc=%0d want 8 and 10", nm, cyc);
        else n_pass++;
    endtask

    task automatic test_halt();
        int bad;
        instr = 16'hE000;
        mem_ack = 1'b1; @(posedge clk); #1;   // FETCH -> DECODE
        mem_ack = 1'b0; @(posedge clk); #1;   // DECODE -> HALT
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            mem_ack = 1'b1; #1;
            n_chk++;
            if (state !== 4'd9 || illegal !== 1'b1 || mem_req !== 1'b0) begin
                $display("FAIL halt_hold cycle %0d got st=%0d ill=%b req=%b want 9,1,0",
                         i, state, illegal, mem_req);
                bad++;
            end else n_pass++;
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;
        reset = 1'b1; #1;
        n_chk++;
        if (illegal !== 1'b0) $display("FAIL halt_reset_illegal got %b want 0", illegal);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        n_chk++;
        if (state !== 4'd0 || mem_req !== 1'b1)
            $display("FAIL halt_exit got st=%0d req=%b want 0,1", state, mem_req);
        else n_pass++;
    endtask

    task automatic test_reset_mid_multi();
        instr = 16'h6010;                      // LM, mask bit 4 only
        mem_ack = 1'b1; @(posedge clk); #1;    // FETCH
        mem_ack = 1'b0; @(posedge clk); #1;    // DECODE
        for (int i = 0; i < 6; i++) begin      // idx 0..3 idle, then stall at 4
            @(posedge clk); #1;
        end
        n_chk++;
        if (state !== 4'd6 || mem_req !== 1'b1)
            $display("FAIL multi_stall got st=%0d req=%b want 6,1", state, mem_req);
        else n_pass++;
        reset = 1'b1; mem_ack = 1'b1; #1;
        n_chk++;
        if (rf_we !== 1'b0 || t3_inc !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL multi_reset_quiet got rf_we=%b t3_inc=%b req=%b want 0,0,0",
                     rf_we, t3_inc, mem_req);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b0; #1;
        n_chk++;
        if (state !== 4'd0 || mem_req !== 1'b1)
            $display("FAIL multi_reset_fetch got st=%0d req=%b want 0,1", state, mem_req);
        else n_pass++;
        run_instr(16'h6A05, 0, 1'b0, 1'b0);
        n_chk++;
        if (timeout || wr_q.size() != 2 || wr_q[0] !== {3'd0, 2'd1} || cyc != 10)
            $display("FAIL multi_after_reset got writes=%p cyc=%0d want 0,2 and 10", wr_q, cyc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] ops[14];
        logic [15:0] ins;
        bit z, n, ok;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hF};
        for (int k = 0; k < 40; k++) begin
            ins = {ops[$urandom_range(0, 13)], 12'($urandom)};
            z = 1'($urandom_range(0, 1));
            n = 1'($urandom_range(0, 1));
            build_model(ins, z, n);
            run_instr(ins, -1, z, n);
            n_chk++;
            if (timeout || cyc != e_base + waits)
                $display("FAIL rnd_cycles ins=%h got %0d want %0d", ins, cyc, e_base + waits);
            else n_pass++;
            ok = (wr_q.size() == e_wr.size());
            if (ok) foreach (e_wr[i]) if (wr_q[i] !== e_wr[i]) ok = 0;
            n_chk++;
            if (!ok) $display("FAIL rnd_writes ins=%h got %p want %p", ins, wr_q, e_wr);
            else n_pass++;
            ok = (pcs_q.size() == e_pcs.size());
            if (ok) foreach (e_pcs[i]) if (pcs_q[i] !== e_pcs[i]) ok = 0;
            n_chk++;
            if (!ok) $display("FAIL rnd_pc ins=%h z=%b n=%b got %p want %p", ins, z, n, pcs_q, e_pcs);
            else n_pass++;
            ok = (accwe_q.size() == e_acc.size());
            if (ok) foreach (e_acc[i]) if (accwe_q[i] !== e_acc[i]) ok = 0;
            n_chk++;
            if (!ok) $display("FAIL rnd_mem ins=%h got %p want %p", ins, accwe_q, e_acc);
            else n_pass++;
            n_chk++;
            if (t3i != e_t3i || fl != e_fl)
                $display("FAIL rnd_strobes ins=%h got t3_inc=%0d flags=%0d want %0d %0d",
                         ins, t3i, fl, e_t3i, e_fl);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0; instr = 16'h0;
        test_reset();
        test_add_trace();
        test_lw_wait();
        test_branch();
        test_lm();
        test_halt();
        test_reset_mid_multi();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle control unit for the 16-bit processor. It steps each instruction through fetch, decode, execute, memory and write-back. Every cycle it drives the datapath strobes: PC, IR, temporary registers T1–T3, ALU, register-file write port, flags and the memory handshake. It takes the opcode field `instr[15:12]` and the register/mask fields from the IR. It also takes the ALU status from the datapath, and iterates LM/SM over an 8-bit register mask.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 0. Reserved; must be 0. There is no timeout, and the block waits indefinitely for `mem_ack`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in 16: IR contents, stable from DECODE until the next `ir_load`.
  - RA = `[11:9]`, RB = `[8:6]`, RC = `[5:3]`, mask = `[7:0]`.
- `mem_ack` in 1: memory completes the current access this cycle. Only meaningful while `mem_req`=1.
- `alu_zero`, `alu_neg` in 1 each: combinational ALU status. `alu_neg` is the sign bit of the result.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: write access; valid only with `mem_req`.
- `addr_sel` out 1: 0 = PC, 1 = T3.
- `ir_load` out 1: load IR.
- `pc_load` out 1: load PC.
- `pc_sel` out 2: 00 PC+1, 01 PC+sext(imm), 10 RB value.
- `t_load` out 1: load T1←R[RA], T2←R[RB].
- `alu_op` out 2: 00 add, 01 nand, 10 sub, 11 pass-B.
- `alu_src_b` out 1: 0 = T2, 1 = sext(imm).
- `t3_load` out 1: T3←ALU result.
- `t3_inc` out 1: T3←T3+1.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 3: write register index.
- `rf_wsel` out 2: 00 T3, 01 mem data, 10 PC, 11 imm.
- `flags_load` out 1: load carry/zero flags.
- `illegal` out 1: sticky illegal-opcode indicator.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM_RD=3, MEM_WR=4, WB=5, MULTI=6, BRANCH=7, JUMP=8, HALT=9.
- All outputs are combinational from state, the opcode latch and inputs. Every output is 0 while `reset`=1, except `state`.
- FETCH:
  - Drives `mem_req`=1 and `addr_sel`=0.
  - On `mem_ack`: `ir_load`, `pc_load` with `pc_sel`=00, then → DECODE.
  - Without `mem_ack`: stays in FETCH.
- DECODE:
  - Drives `t_load`=1 and latches the opcode class.
  - Latches the mask and clears the 3-bit index counter.
  - Next state by class:
    - 0000 ADI, 0001 ADD-family, 0010 NAND-family, 0100 LW, 0101 SW, 1000 BEQ, 1001 BLT, 1010 BLE → EXEC.
    - 0011 LLI → WB.
    - 0110 LM, 0111 SM → MULTI.
    - 1100 JAL, 1101 JLR, 1111 JRI → JUMP.
    - 1011, 1110 → HALT.
- EXEC:
  - ALU-R (0001 add, 0010 nand): `alu_src_b`=0, `t3_load`, `flags_load` → WB.
  - ADI: add with `alu_src_b`=1, `t3_load`, `flags_load` → WB.
  - LW/SW: add with `alu_src_b`=1, `t3_load`, no `flags_load` → MEM_RD / MEM_WR.
  - Branches: sub with T2, no `flags_load` → BRANCH.
- MEM_RD:
  - Drives `mem_req`=1 and `addr_sel`=1.
  - On `mem_ack`: `rf_we`, `rf_wsel`=01, `rf_waddr`=RA → FETCH.
- MEM_WR:
  - Drives `mem_req`=1, `mem_we`=1, `addr_sel`=1.
  - On `mem_ack` → FETCH.
- WB: single cycle with `rf_we`=1, then → FETCH.
  - ALU-R writes RC, `rf_wsel`=00.
  - ADI writes RB, `rf_wsel`=00.
  - LLI writes RA, `rf_wsel`=11.
- BRANCH:
  - Taken condition: BEQ `alu_zero`; BLT `alu_neg`; BLE `alu_zero|alu_neg`.
  - If taken, `pc_load` with `pc_sel`=01.
  - Always → FETCH.
- JUMP:
  - Writes the link in the same cycle: `rf_we`, `rf_wsel`=10, `rf_waddr`=RA.
  - Loads the new PC: JAL/JRI `pc_sel`=01; JLR `pc_sel`=10.
  - → FETCH.
- MULTI (LM/SM):
  - T3 is first loaded in the DECODE cycle via `alu_op`=11, `alu_src_b`=0, `t3_load`=1, so T3 = RB value.
  - Each MULTI cycle examines mask bit [idx].
  - Bit clear:
    - idx++.
    - If idx was 7 → FETCH.
  - Bit set:
    - `mem_req`=1, `addr_sel`=1, `mem_we` = (SM).
    - On `mem_ack`: `t3_inc`, idx++.
    - On `mem_ack` for LM also: `rf_we`, `rf_wsel`=01, `rf_waddr`=idx.
    - After idx 7 → FETCH.
    - Without `mem_ack`: hold state and idx.
- HALT: `illegal`=1, absorbing; only `reset` leaves it.
- The PC+1 during FETCH precedes every PC-relative computation. PC+imm therefore uses the already-incremented PC.

## Timing
- Reset values:
  - State = FETCH, idx = 0, `illegal` = 0.
  - All outputs 0 during the reset cycle.
  - `mem_req`=1 in the first cycle after reset deasserts.
- Reset asserted in any state, including mid-MULTI or mid-wait, gives FETCH at the next edge. Any pending access is abandoned.
- `mem_ack` may arrive in the first cycle of `mem_req`, which is a zero-wait access.
- Each wait cycle on `mem_ack` adds exactly one cycle.
- `mem_req` and its qualifiers stay stable until `mem_ack`.
- Latencies with zero-wait memory:

| Instruction | Cycles |
|---|---|
| ALU / ADI | 4 |
| LLI | 3 |
| LW / SW | 4 |
| Branch | 4 |
| Jump | 3 |
| LM/SM | 2 + 8 |

  - LM/SM costs 8 MULTI cycles regardless of popcount. It is 2 + 8 plus wait cycles.
  - A mask of 0x00 gives 8 idle MULTI cycles and then FETCH.
- Index wrap: idx is 3 bits, 7+1 wraps to 0. The state has already left MULTI when this happens.

## Test plan
- Reset, then 0x1298 (ADD) with zero-wait memory:
  - States 0,1,2,5,0 on consecutive cycles.
  - WB asserts `rf_we`=1 with `rf_waddr`=3.
- LW 0x4A85 with 2 wait cycles in MEM_RD:
  - `mem_req` held for 3 cycles, `addr_sel`=1.
  - `rf_we` and `rf_waddr`=5 assert only in the ack cycle.
- BEQ:
  - With `alu_zero`=1: BRANCH asserts `pc_load` with `pc_sel`=01.
  - With `alu_zero`=0 and `alu_neg`=1: no `pc_load`.
  - BLE with `alu_neg`=1: taken.
- LM 0x6A05 (mask 0000_0101):
  - Exactly 2 memory reads, writing `rf_waddr` 0 then 2.
  - Two `t3_inc` pulses, 8 MULTI cycles, then FETCH.
- Opcode 1110:
  - After DECODE, state=9 and `illegal`=1, held for 20 cycles with no `mem_req`.
  - Reset clears it and the next cycle shows `mem_req`=1.
- Reset asserted mid-MULTI at idx 4 while waiting on ack:
  - Next state FETCH, idx 0.
  - No `rf_we` in the reset cycle.
